seq_shifter: RTL and testbench
==============================

Name: seq_shifter

Overview:
- Multicycle shift unit for the KGP-RISC execute stage; handles the SLL, SRL and SRA instructions.
- Performs a register-amount shift one bit per cycle (optionally four bits per cycle).
- Its registered result drives the shift-result data input of the 4-to-1 writeback select mux.
- Writeback select logic must wait for `done` before steering the mux to this input.

Parameters:
- WIDTH, 32, data width of the operand and result.
- SHAMT_W, 5, width of the shift amount; must satisfy 2**SHAMT_W == WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on the rising edge while in IDLE or DONE.
- op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 PASS.
- din  input  WIDTH  operand to shift.
- shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- busy  output  1  high while shifting is in progress.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  WIDTH  registered shift result; held until the next accepted start.

Behaviour:
- Reset: on any edge with rst=1, state←IDLE, result←0, busy=0, done=0. This applies mid-operation too: a shift in progress is discarded and no done pulse is issued.
- State machine has three states: IDLE, SHIFT, DONE.
- busy = (state==SHIFT). done = (state==DONE). Both are decoded from registered state only.
- Accepting a request (IDLE or DONE with start=1):
  - Load working register ← din, op_q ← op, cnt ← shamt.
  - If shamt==0 or op==PASS, go to DONE; otherwise go to SHIFT.
- SHIFT state, on each edge:
  - Shift the working register by 1: SLL fills with 0 at the LSB; SRL fills with 0 at the MSB; SRA replicates the MSB.
  - cnt ← cnt-1. When cnt==1 before the decrement, go to DONE.
- result is the working register itself and is stable in DONE and IDLE. The bench checks result only when done=1.
- Latency: if start is sampled on edge E, done is high in cycle E+N+1, where N = shamt (N=0 for PASS). Worst case is 32 cycles.
- A start arriving during SHIFT is ignored and not queued; the upstream stage stalls while busy=1.
- A start during DONE is accepted (back-to-back operation). done still pulses for exactly one cycle, and the next result replaces the old one on the following edge.
- DONE with start=0 returns to IDLE.
- rst and start on the same edge: rst wins.
- Inputs are sampled only on the accepting edge; they may change freely afterwards.

Optional Feature:
- Macro: SEQ_SHIFTER_RADIX4_EN.
- Defined: each SHIFT cycle shifts by 4 when cnt≥4, otherwise by 1; cnt decrements by the same step. Leave SHIFT when the remaining count reaches 0. Latency = floor(N/4) + (N mod 4) + 1 cycles; N=31 gives done at E+11.
- Undefined: radix-1 behaviour exactly as described in Behaviour.
- Results are bit-identical in both builds.

Decomposition:
- Package kgp_shift_pkg holds:
  - op encodings SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_PASS=2'b11;
  - the state enum {IDLE, SHIFT, DONE};
  - WIDTH and SHAMT_W defaults.
- Sub-module shift_step is a combinational single-step shifter (inputs: data, op, step of 1 or 4; output: shifted data). It is instantiated once.

Test Plan:
1. Reset then idle: rst high for 2 cycles mid-shift (SLL, shamt=20, start 5 cycles earlier) → busy=0, done=0, result=0; no done pulse follows.
2. SLL: din=0x0000_00F1, shamt=4, start at edge E → busy high during E+1..E+4, done only at E+5, result=0x0000_0F10.
3. SRA: din=0x8000_0000, shamt=31 → done at E+32, result=0xFFFF_FFFF. SRL with the same inputs → result=0x0000_0001.
4. shamt=0, op=SLL, din=0x1234_5678; and PASS with shamt=7 → done at E+1, result=0x1234_5678 in both cases.
5. Back-to-back and ignored start:
   - start pulsed during SHIFT → ignored.
   - start during the DONE cycle (SRL 0xF000_0000 by 8) → accepted; done at 9 cycles later, result=0x00F0_0000.
6. With SEQ_SHIFTER_RADIX4_EN defined: SLL din=1, shamt=31 → done at E+11, result=0x8000_0000. Also run a 1000-vector random comparison against the radix-1 build.

Source files
------------

// File: rtl/seq_shifter_pkg.sv
// Shared definitions for the KGP-RISC multicycle shift unit: op codes,
// FSM states and default widths.
package kgp_shift_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;

    localparam logic [1:0] SH_SLL  = 2'b00;
    localparam logic [1:0] SH_SRL  = 2'b01;
    localparam logic [1:0] SH_SRA  = 2'b10;
    localparam logic [1:0] SH_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// Combinational single-step shifter: moves data by 1 or 4 bit positions
// according to the shift op. PASS (and any unknown op) returns data unchanged.
module shift_step
    import kgp_shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       op,
    input  logic             step4,
    output logic [WIDTH-1:0] shifted
);

    always_comb begin
        // NOTE: default assigned first so every path drives shifted; no latch.
        shifted = data;
        case (op)
            SH_SLL:  shifted = step4 ? {data[WIDTH-5:0], 4'b0000}
                                     : {data[WIDTH-2:0], 1'b0};
            SH_SRL:  shifted = step4 ? {4'b0000, data[WIDTH-1:4]}
                                     : {1'b0, data[WIDTH-1:1]};
            SH_SRA:  shifted = step4 ? {{4{data[WIDTH-1]}}, data[WIDTH-1:4]}
                                     : {data[WIDTH-1], data[WIDTH-1:1]};
            default: shifted = data;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multicycle SLL/SRL/SRA unit for the execute stage, one bit per SHIFT cycle.
// Define SEQ_SHIFTER_RADIX4_EN to shift four bits per cycle while cnt >= 4.
module seq_shifter
    import kgp_shift_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   din,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [1:0]         op_q, op_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               step4;
    logic [SHAMT_W-1:0] step_amt;
    logic [WIDTH-1:0]   stepped;

`ifdef SEQ_SHIFTER_RADIX4_EN
    assign step4 = (cnt_q >= SHAMT_W'(4));
`else
    assign step4 = 1'b0;
`endif
    assign step_amt = step4 ? SHAMT_W'(4) : SHAMT_W'(1);

    shift_step #(.WIDTH(WIDTH)) u_step (
        .data    (work_q),
        .op      (op_q),
        .step4   (step4),
        .shifted (stepped)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    work_d  = din;
                    op_d    = op;
                    cnt_d   = shamt;
                    state_d = (shamt == '0 || op == SH_PASS) ? DONE : SHIFT;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // Requests arriving here are dropped; upstream stalls on busy.
                work_d = stepped;
                cnt_d  = cnt_q - step_amt;
                if (cnt_q == step_amt) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments only; the synchronous reset covers every
    // register so an aborted shift leaves no stale state behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            op_q    <= SH_SLL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == DONE);
    assign result = work_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed vector table, reset and
// ignored-start sequences, plus random vectors against a behavioural model.
module tb_seq_shifter;
    import kgp_shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] din;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    seq_shifter dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .din    (din),
        .shamt  (shamt),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] din;
        logic [4:0]  shamt;
        logic [31:0] exp;
        bit          b2b;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Edges from the accepting edge (inclusive) until done is visible.
    function automatic int exp_edges(input logic [1:0] o, input logic [4:0] s);
        int n;
        n = (o == SH_PASS) ? 0 : int'(s);
`ifdef SEQ_SHIFTER_RADIX4_EN
        return n / 4 + n % 4 + 1;
`else
        return n + 1;
`endif
    endfunction

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
        case (o)
            SH_SLL:  return d << s;
            SH_SRL:  return d >> s;
            SH_SRA:  return $unsigned($signed(d) >>> s);
            default: return d;
        endcase
    endfunction

    // Called at a negedge; drives a request, returns at the negedge where done
    // is seen. glitch_at > 0 pulses start (with junk inputs) after that many edges.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] d,
                          input logic [4:0] s, input logic [31:0] e, input int glitch_at);
        int n;
        bit busy_ok;
        n = 0;
        busy_ok = 1'b1;
        op = o; din = d; shamt = s; start = 1'b1;
        while (n < 64) begin
            @(negedge clk);
            n++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            start = (n == glitch_at);
            op = ~o; din = ~d; shamt = ~s;
        end
        start = 1'b0;
        check({name, "_latency"}, 32'(n), 32'(exp_edges(o, s)));
        check({name, "_result"}, result, e);
        check({name, "_busy_while_shifting"}, 32'(busy_ok), 32'd1);
        check({name, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{SH_SLL,  32'h0000_00F1, 5'd4,  32'h0000_0F10, 1'b0};
        vecs[1]  = '{SH_SRA,  32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{SH_SRL,  32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0};
        vecs[3]  = '{SH_SLL,  32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0};
        vecs[4]  = '{SH_PASS, 32'h1234_5678, 5'd7,  32'h1234_5678, 1'b0};
        vecs[5]  = '{SH_SRL,  32'hF000_0000, 5'd8,  32'h00F0_0000, 1'b1};
        vecs[6]  = '{SH_SLL,  32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
        vecs[7]  = '{SH_SRA,  32'h7000_0000, 5'd4,  32'h0700_0000, 1'b1};
        vecs[8]  = '{SH_SRA,  32'hF000_000F, 5'd5,  32'hFF80_0000, 1'b0};
        vecs[9]  = '{SH_SLL,  32'h8000_0001, 5'd1,  32'h0000_0002, 1'b1};
        vecs[10] = '{SH_SRL,  32'hA5A5_A5A5, 5'd3,  32'h14B4_B4B4, 1'b0};
        vecs[11] = '{SH_SLL,  32'hA5A5_A5A5, 5'd6,  32'h6969_6940, 1'b1};

        rst = 1'b1; start = 1'b0; op = SH_SLL; din = '0; shamt = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            if (!vecs[i].b2b) begin
                @(negedge clk);
                check($sformatf("vec%0d_idle_busy", i), 32'(busy), 32'd0);
                check($sformatf("vec%0d_idle_done", i), 32'(done), 32'd0);
            end
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].din, vecs[i].shamt, vecs[i].exp, 0);
        end

        // Start pulsed mid-shift must be dropped, not queued.
        @(negedge clk);
        run_op("ignored_start", SH_SLL, 32'h0000_00F1, 5'd4, 32'h0000_0F10, 2);
        @(negedge clk);
        check("ignored_start_not_queued_busy", 32'(busy), 32'd0);
        check("ignored_start_not_queued_done", 32'(done), 32'd0);

        // Reset mid-shift discards the operation.
        op = SH_SLL; din = 32'h0000_0003; shamt = 5'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_result", result, 32'd0);
        rst = 1'b0;
        begin
            bit saw_done;
            saw_done = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (done || busy) saw_done = 1'b1;
            end
            check("midreset_no_done_pulse", 32'(saw_done), 32'd0);
        end

        // rst and start on the same edge: reset wins.
        run_op("pre_rst_start", SH_PASS, 32'hCAFE_F00D, 5'd0, 32'hCAFE_F00D, 0);
        rst = 1'b1; start = 1'b1; op = SH_PASS; din = 32'h5555_5555; shamt = '0;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_start_done", 32'(done), 32'd0);
        check("rst_start_result", result, 32'd0);
        @(negedge clk);
        check("rst_start_no_late_done", 32'(done), 32'd0);

        // Random vectors against the behavioural model, mixing idle gaps and b2b.
        for (int k = 0; k < 24; k++) begin
            logic [1:0]  ro;
            logic [31:0] rd;
            logic [4:0]  rs;
            ro = 2'($urandom_range(0, 3));
            rd = $urandom;
            rs = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            run_op($sformatf("rand%0d", k), ro, rd, rs, model(ro, rd, rs), 0);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
